// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage: load alignment/extension, misalign detection, retired-write counter.
// Latency 1 cycle accept->wb_valid; 2-entry skid buffer keeps mem_ready a pure register output.
module memwb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [XLEN-1:0]           mem_rd_data,
  input  logic [XLEN-1:0]           mem_load_data,
  input  logic [$clog2(XLEN/8)-1:0] mem_addr_lsb,
  input  logic [2:0]                mem_funct3,
  input  logic [REG_AW-1:0]         mem_write_addr,
  input  logic                      mem_regwrite,
  input  logic                      mem_memtoreg,
  input  logic                      flush,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [XLEN-1:0]           wb_write_data,
  output logic [REG_AW-1:0]         wb_write_addr,
  output logic                      wb_regwrite,
  output logic                      wb_misalign,
  output logic [CNT_W-1:0]          wb_retired
);

  logic [2:0]        w_off;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_data;
  logic              w_mis_raw;
  logic              w_mis;
  logic              w_we;
  logic              w_acc;
  logic              w_xfer;

  logic              r_wb_valid;
  logic [XLEN-1:0]   r_out_data;
  logic [REG_AW-1:0] r_out_addr;
  logic              r_out_we;
  logic              r_out_mis;
  logic              r_skid_valid;
  logic [XLEN-1:0]   r_skid_data;
  logic [REG_AW-1:0] r_skid_addr;
  logic              r_skid_we;
  logic              r_skid_mis;
  logic [CNT_W-1:0]  r_retired;

  always_comb begin
    w_off     = 3'(mem_addr_lsb);
    w_shift   = mem_load_data >> {mem_addr_lsb, 3'b000};
    w_ext     = '0;
    w_mis_raw = 1'b0;
    case (mem_funct3)
      3'd0: w_ext = XLEN'($signed(w_shift[7:0]));
      3'd1: w_ext = XLEN'($signed(w_shift[15:0]));
      3'd2: w_ext = XLEN'($signed(w_shift[31:0]));
      3'd3: w_ext = (XLEN == 64) ? w_shift : XLEN'($signed(w_shift[31:0]));
      3'd4: w_ext = XLEN'(w_shift[7:0]);
      3'd5: w_ext = XLEN'(w_shift[15:0]);
      3'd6: w_ext = XLEN'(w_shift[31:0]);
      default: w_ext = mem_load_data;
    endcase
    // LD on a 32-bit datapath is a word access, so only two offset bits matter
    case (mem_funct3)
      3'd1, 3'd5: w_mis_raw = w_off[0];
      3'd2, 3'd6: w_mis_raw = (w_off[1:0] != 2'd0);
      3'd3:       w_mis_raw = (XLEN == 64) ? (w_off != 3'd0) : (w_off[1:0] != 2'd0);
      default:    w_mis_raw = 1'b0;
    endcase
    w_mis  = mem_memtoreg & w_mis_raw;
    w_data = mem_memtoreg ? w_ext : mem_rd_data;
    w_we   = mem_regwrite & ~w_mis;
  end

  assign w_acc  = mem_valid & mem_ready;
  assign w_xfer = r_wb_valid & wb_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid   <= 1'b0;
      r_out_data   <= '0;
      r_out_addr   <= '0;
      r_out_we     <= 1'b0;
      r_out_mis    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_addr  <= '0;
      r_skid_we    <= 1'b0;
      r_skid_mis   <= 1'b0;
    end else if (flush) begin
      r_wb_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_wb_valid || w_xfer) begin
      if (r_skid_valid) begin
        r_wb_valid   <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_addr   <= r_skid_addr;
        r_out_we     <= r_skid_we;
        r_out_mis    <= r_skid_mis;
        r_skid_valid <= 1'b0;
      end else begin
        r_wb_valid <= w_acc;
        if (w_acc) begin
          r_out_data <= w_data;
          r_out_addr <= mem_write_addr;
          r_out_we   <= w_we;
          r_out_mis  <= w_mis;
        end
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_data;
      r_skid_addr  <= mem_write_addr;
      r_skid_we    <= w_we;
      r_skid_mis   <= w_mis;
    end
  end

  // A transfer in the flush cycle still retires its write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (w_xfer && r_out_we) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign mem_ready     = ~r_skid_valid;
  assign wb_valid      = r_wb_valid;
  assign wb_write_data = r_out_data;
  assign wb_write_addr = r_out_addr;
  assign wb_regwrite   = r_wb_valid & r_out_we;
  assign wb_misalign   = r_out_mis;
  assign wb_retired    = r_retired;

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: queue-based reference model with random traffic plus directed load cases.
module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // XLEN=32, CNT_W=4 instance
  logic        m_valid, m_ready, m_we, m_m2r, fl, wb_rdy;
  logic [31:0] m_rd, m_ld;
  logic [1:0]  m_off;
  logic [2:0]  m_f3;
  logic [4:0]  m_waddr;
  logic        o_valid, o_we, o_mis;
  logic [31:0] o_data;
  logic [4:0]  o_addr;
  logic [3:0]  o_ret;

  // XLEN=64 instance
  logic        d_valid, d_ready, d_we, d_m2r, d_fl, d_wbrdy;
  logic [63:0] d_rd, d_ld;
  logic [2:0]  d_off;
  logic [2:0]  d_f3;
  logic [4:0]  d_waddr;
  logic        d_ovalid, d_owe, d_omis;
  logic [63:0] d_odata;
  logic [4:0]  d_oaddr;
  logic [31:0] d_oret;

  memwb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) u32 (
    .clk(clk), .reset(rst_n),
    .mem_valid(m_valid), .mem_ready(m_ready),
    .mem_rd_data(m_rd), .mem_load_data(m_ld), .mem_addr_lsb(m_off),
    .mem_funct3(m_f3), .mem_write_addr(m_waddr), .mem_regwrite(m_we),
    .mem_memtoreg(m_m2r), .flush(fl),
    .wb_valid(o_valid), .wb_ready(wb_rdy), .wb_write_data(o_data),
    .wb_write_addr(o_addr), .wb_regwrite(o_we), .wb_misalign(o_mis),
    .wb_retired(o_ret)
  );

  memwb_stage #(.XLEN(64), .REG_AW(5), .CNT_W(32)) u64 (
    .clk(clk), .reset(rst_n),
    .mem_valid(d_valid), .mem_ready(d_ready),
    .mem_rd_data(d_rd), .mem_load_data(d_ld), .mem_addr_lsb(d_off),
    .mem_funct3(d_f3), .mem_write_addr(d_waddr), .mem_regwrite(d_we),
    .mem_memtoreg(d_m2r), .flush(d_fl),
    .wb_valid(d_ovalid), .wb_ready(d_wbrdy), .wb_write_data(d_odata),
    .wb_write_addr(d_oaddr), .wb_regwrite(d_owe), .wb_misalign(d_omis),
    .wb_retired(d_oret)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: access size from funct3, then shift/mask/extend arithmetically
  function automatic int acc_size(int f3, int xlen);
    case (f3 % 4)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return (xlen == 64) ? 8 : 4;
    endcase
  endfunction

  function automatic logic [63:0] ref_ext(logic [63:0] ld, int xlen, int off, int f3);
    logic [63:0] v;
    logic [63:0] mask;
    int sz;
    if (f3 == 7) return ld;
    sz = acc_size(f3, xlen);
    v  = ld >> (8 * off);
    if (sz < 8) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (f3 < 4 && v[8*sz-1]) v = v | ~mask;
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic ref_mis(int xlen, int off, int f3, logic m2r);
    if (!m2r || f3 == 7) return 1'b0;
    return (off % acc_size(f3, xlen)) != 0;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    logic        mis;
  } ent_t;

  ent_t     q[$];
  int       ret_m = 0;

  task automatic check_state();
    chk("mem_ready", m_ready, q.size() < 2);
    chk("wb_valid", o_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("wb_data", o_data, q[0].data);
      chk("wb_addr", o_addr, q[0].addr);
      chk("wb_regwrite", o_we, q[0].we);
      chk("wb_misalign", o_mis, q[0].mis);
    end else begin
      chk("wb_regwrite_idle", o_we, 1'b0);
    end
    chk("wb_retired", o_ret, ret_m[3:0]);
  endtask

  // Called at negedge with inputs set; advances one cycle and checks at the next negedge
  task automatic step();
    ent_t e;
    logic acc, xfer;
    acc  = m_valid && (q.size() < 2);
    xfer = (q.size() > 0) && wb_rdy;
    if (xfer) begin
      if (q[0].we) ret_m = (ret_m + 1) % 16;
      void'(q.pop_front());
    end
    if (fl) q.delete();
    else if (acc) begin
      e.mis  = ref_mis(32, int'(m_off), int'(m_f3), m_m2r);
      e.data = m_m2r ? ref_ext({32'd0, m_ld}, 32, int'(m_off), int'(m_f3)) : m_rd;
      e.addr = m_waddr;
      e.we   = m_we && !e.mis;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic send32(input logic [31:0] ld, input logic [1:0] off, input logic [2:0] f3,
                        input logic m2r, input logic we);
    m_valid = 1'b1; m_ld = ld; m_off = off; m_f3 = f3; m_m2r = m2r; m_we = we;
    m_rd = $urandom; m_waddr = 5'($urandom);
    step();
    m_valid = 1'b0;
  endtask

  task automatic send64(input logic [63:0] ld, input logic [2:0] off, input logic [2:0] f3,
                        input logic [63:0] exp, input string tag);
    d_valid = 1'b1; d_ld = ld; d_off = off; d_f3 = f3; d_m2r = 1'b1; d_we = 1'b1;
    step();
    d_valid = 1'b0;
    chk(tag, d_odata, exp);
    chk({tag, "_model"}, d_odata, ref_ext(ld, 64, int'(off), int'(f3)));
    chk({tag, "_valid"}, d_ovalid, 1'b1);
  endtask

  initial begin
    int ret_before;
    rst_n = 1'b0;
    m_valid = 0; m_rd = 0; m_ld = 0; m_off = 0; m_f3 = 0; m_waddr = 0;
    m_we = 0; m_m2r = 0; fl = 0; wb_rdy = 1;
    d_valid = 0; d_rd = 0; d_ld = 0; d_off = 0; d_f3 = 0; d_waddr = 3;
    d_we = 0; d_m2r = 0; d_fl = 0; d_wbrdy = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", m_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_addr", o_addr, 5'd0);
    chk("rst_we", o_we, 1'b0);
    chk("rst_mis", o_mis, 1'b0);
    chk("rst_ret", o_ret, 4'd0);
    rst_n = 1'b1;
    step();

    // 17 back-to-back retiring writes wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    step();
    chk("retired_wrap", o_ret, 4'd1);

    send32(32'h8000_F0A5, 2'd0, 3'd0, 1'b1, 1'b1); chk("lb",   o_data, 32'hFFFF_FFA5);
    send32(32'h8000_F0A5, 2'd0, 3'd4, 1'b1, 1'b1); chk("lbu",  o_data, 32'h0000_00A5);
    send32(32'h8000_F0A5, 2'd0, 3'd1, 1'b1, 1'b1); chk("lh",   o_data, 32'hFFFF_F0A5);
    send32(32'h8000_F0A5, 2'd0, 3'd5, 1'b1, 1'b1); chk("lhu",  o_data, 32'h0000_F0A5);
    send32(32'h8000_F0A5, 2'd2, 3'd1, 1'b1, 1'b1); chk("lh_o2", o_data, 32'hFFFF_8000);
    step();
    ret_before = int'(o_ret);
    send32(32'h1234_5678, 2'd1, 3'd2, 1'b1, 1'b1);
    chk("lw_mis", o_mis, 1'b1);
    chk("lw_mis_we", o_we, 1'b0);
    step();
    chk("lw_mis_noret", o_ret, 4'(ret_before));
    send32(32'h8000_F0A5, 2'd3, 3'd0, 1'b1, 1'b1);
    chk("lb_o3", o_data, 32'hFFFF_FF80);
    chk("lb_o3_mis", o_mis, 1'b0);
    step();

    // Back-pressure: A held, B in skid, then drain in order
    wb_rdy = 1'b0;
    send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    chk("bp_ready_low", m_ready, 1'b0);
    wb_rdy = 1'b1;
    step();
    chk("bp_ready_back", m_ready, 1'b1);
    step();
    chk("bp_drained", o_valid, 1'b0);

    // Flush with both entries held and a simultaneous offer
    wb_rdy = 1'b0;
    send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    fl = 1'b1; m_valid = 1'b1; m_rd = 32'hDEAD_BEEF;
    step();
    fl = 1'b0; m_valid = 1'b0;
    chk("fl_valid", o_valid, 1'b0);
    chk("fl_ready", m_ready, 1'b1);
    wb_rdy = 1'b1;
    step();
    chk("fl_no_new", o_valid, 1'b0);
    // Flush on an empty stage drops the accepted entry
    fl = 1'b1; m_valid = 1'b1;
    step();
    fl = 1'b0; m_valid = 1'b0;
    chk("fl_drop", o_valid, 1'b0);

    send64(64'h8123_4567_89AB_CDEF, 3'd0, 3'd3, 64'h8123_4567_89AB_CDEF, "ld64");
    send64(64'h8123_4567_89AB_CDEF, 3'd4, 3'd2, 64'hFFFF_FFFF_8123_4567, "lw64");
    send64(64'h8123_4567_89AB_CDEF, 3'd4, 3'd6, 64'h0000_0000_8123_4567, "lwu64");
    d_valid = 1'b1; d_ld = 64'h1; d_off = 3'd4; d_f3 = 3'd3; d_m2r = 1'b1; d_we = 1'b1;
    step();
    d_valid = 1'b0;
    chk("ld64_mis", d_omis, 1'b1);
    chk("ld64_mis_we", d_owe, 1'b0);

    for (int i = 0; i < 600; i++) begin
      m_valid = ($urandom_range(0, 3) != 0);
      wb_rdy  = ($urandom_range(0, 2) != 0);
      fl      = ($urandom_range(0, 24) == 0);
      m_rd    = $urandom;
      m_ld    = $urandom;
      m_off   = 2'($urandom);
      m_f3    = 3'($urandom);
      m_waddr = 5'($urandom);
      m_we    = $urandom_range(0, 1) == 1;
      m_m2r   = $urandom_range(0, 1) == 1;
      step();
    end

    // Reset asserted mid-stream clears everything without a clock edge
    fl = 1'b0; wb_rdy = 1'b0;
    send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    send32(32'h0, 2'd0, 3'd2, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_ready", m_ready, 1'b1);
    chk("arst_data", o_data, 32'd0);
    chk("arst_we", o_we, 1'b0);
    chk("arst_ret", o_ret, 4'd0);
    q.delete();
    ret_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_rdy = 1'b1;
    send32(32'h8000_F0A5, 2'd0, 3'd4, 1'b1, 1'b1);
    chk("post_rst_lbu", o_data, 32'h0000_00A5);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- Parametrised MEM/WB pipeline stage between the data-memory stage and the register-file write port.
- Registers MEM results and performs load-data alignment and sign/zero extension for all RISC-V load widths up to XLEN.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so writeback back-pressure never creates a combinational ready path.
- Adds flush, misalignment detection and a retired-write counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- mem_valid  input  1  MEM stage presents a valid instruction.
- mem_ready  output  1  stage can accept; registered, equals !skid_valid.
- mem_rd_data  input  XLEN  ALU/forwarded result.
- mem_load_data  input  XLEN  raw data-memory read word.
- mem_addr_lsb  input  log2(XLEN/8)  byte offset of load address.
- mem_funct3  input  3  load type.
- mem_write_addr  input  REG_AW  destination register.
- mem_regwrite  input  1  instruction writes rd.
- mem_memtoreg  input  1  write value comes from memory.
- flush  input  1  synchronous kill of all held entries.
- wb_valid  output  1  output entry valid.
- wb_ready  input  1  writeback consumes entry.
- wb_write_data  output  XLEN  final rd value (load-extended or rd_data).
- wb_write_addr  output  REG_AW  destination register.
- wb_regwrite  output  1  qualified write enable (valid && regwrite && !misalign).
- wb_misalign  output  1  held load was misaligned.
- wb_retired  output  CNT_W  count of completed register writes.

Behaviour:
- Reset (reset low, asynchronous): wb_valid=0, skid_valid=0, mem_ready=1, wb_write_data=0, wb_write_addr=0, wb_regwrite=0, wb_misalign=0, wb_retired=0.
- Accept: mem_valid && mem_ready. Transfer out: wb_valid && wb_ready. Latency is 1 cycle from accept to wb_valid when the output stage is empty or draining.
- Load extraction is combinational on the input side and registered with the entry:
  - shifted = mem_load_data >> (8*mem_addr_lsb).
  - funct3 0 LB: sign-extend shifted[7:0].
  - funct3 1 LH: sign-extend [15:0].
  - funct3 2 LW: [31:0], sign-extended when XLEN=64.
  - funct3 3 LD: XLEN=64 full word; XLEN=32 treated as LW.
  - funct3 4 LBU: zero-extend [7:0].
  - funct3 5 LHU: zero-extend [15:0].
  - funct3 6 LWU: zero-extend [31:0] (XLEN=32: same as LW).
  - funct3 7: raw, unshifted.
- Extraction applies only when mem_memtoreg=1; otherwise the entry data is mem_rd_data.
- Misalign: mem_memtoreg=1 and the offset is not a multiple of the access size (H: bit0; W: bits[1:0]; D: bits[2:0]). A misaligned entry is still transferred, but with wb_misalign=1 and wb_regwrite=0.
- Skid rules:
  - Output empty, or output transferring: the accepted entry goes to the output register.
  - Output held (wb_valid && !wb_ready) and accept: the entry goes to the skid register; skid_valid=1; mem_ready=0 next cycle.
  - Skid full and output transfers: skid moves to output; skid_valid=0.
  - Accept never occurs while the skid is full; no entry is lost or duplicated.
- Flush: next cycle wb_valid=0, skid_valid=0, mem_ready=1. An accept in the same cycle as flush is dropped. Flush has priority over all transfers. wb_retired still counts a transfer occurring in the flush cycle.
- wb_retired increments by 1 on each transfer with wb_regwrite=1 and wraps modulo 2^CNT_W.
- Entries with mem_write_addr=0 pass through unchanged; x0 suppression belongs to the register file.
- A reset assertion mid-stream discards all entries immediately.

Test Plan:
- XLEN=32, load word 0x8000_F0A5 with offset 0: LB -> 0xFFFF_FFA5; LBU -> 0x0000_00A5; LH -> 0xFFFF_F0A5; LHU -> 0x0000_F0A5. Offset 2 with LH -> 0xFFFF_8000. Each result appears on wb_write_data 1 cycle after accept.
- LW at offset 1 with regwrite=1 -> wb_misalign=1, wb_regwrite=0, wb_retired unchanged. LB at offset 3 -> no misalign.
- Back-pressure:
  - hold wb_ready=0 and send entries A, B: A held on output, B in skid, mem_ready=0.
  - raise wb_ready: A then B emerge on consecutive cycles, mem_ready returns to 1, no loss or duplication.
- Flush with both entries full plus a simultaneous mem_valid: next cycle wb_valid=0, mem_ready=1, the new entry never appears.
- XLEN=64: LD of 0x8123_4567_89AB_CDEF -> unchanged; LW at offset 4 -> 0xFFFF_FFFF_8123_4567; LWU -> 0x0000_0000_8123_4567.
- CNT_W=4: 17 regwrite transfers -> wb_retired=1. Drive reset low mid-stream -> all outputs return to reset values asynchronously.
